// File: rtl/random_delay_timer.sv
// Start-triggered delay timer: waits (random_value + MIN_UNITS) * TICKS_PER_UNIT cycles, then pulses done.
// Optional early-press cancel with an early pulse is enabled by defining RDT_EARLY_PRESS_EN.
module random_delay_timer #(
    parameter int unsigned VALUE_WIDTH    = 5,
    parameter int unsigned TICKS_PER_UNIT = 50000,
    parameter int unsigned MIN_UNITS      = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [VALUE_WIDTH-1:0] random_value,
`ifdef RDT_EARLY_PRESS_EN
    input  logic                   press,
    output logic                   early,
`endif
    output logic [VALUE_WIDTH+7:0] delay_units,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned UnitW = VALUE_WIDTH + 8;
    localparam int unsigned PreW  = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
    localparam logic [PreW-1:0] PreMax = PreW'(TICKS_PER_UNIT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [PreW-1:0]    presc_q, presc_d;
    logic [UnitW-1:0]   units_q, units_d;
    logic [UnitW-1:0]   delay_units_q, delay_units_d;
    logic [UnitW-1:0]   sampled_units;
    logic               tick_wrap;
    logic               expire;
`ifdef RDT_EARLY_PRESS_EN
    logic               early_q, early_d;
`endif

    assign sampled_units = UnitW'(random_value) + UnitW'(MIN_UNITS);
    assign tick_wrap     = (presc_q == PreMax);
    // A zero-unit delay still spends one cycle in WAIT.
    assign expire        = (units_q == '0) || ((units_q == UnitW'(1)) && tick_wrap);

    always_comb begin
        state_d       = state_q;
        presc_d       = presc_q;
        units_d       = units_q;
        delay_units_d = delay_units_q;
`ifdef RDT_EARLY_PRESS_EN
        early_d       = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    delay_units_d = sampled_units;
                    presc_d       = '0;
                    units_d       = sampled_units;
                    state_d       = StWait;
                end
            end
            StWait: begin
                if (abort) begin
                    presc_d = '0;
                    units_d = '0;
                    state_d = StIdle;
                end
`ifdef RDT_EARLY_PRESS_EN
                else if (press) begin
                    presc_d = '0;
                    units_d = '0;
                    early_d = 1'b1;
                    state_d = StIdle;
                end
`endif
                else if (expire) begin
                    presc_d = '0;
                    units_d = '0;
                    state_d = StDone;
                end else if (tick_wrap) begin
                    presc_d = '0;
                    units_d = units_q - UnitW'(1);
                end else begin
                    presc_d = presc_q + PreW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                presc_d = '0;
                units_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            presc_q       <= '0;
            units_q       <= '0;
            delay_units_q <= '0;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            units_q       <= units_d;
            delay_units_q <= delay_units_d;
        end
    end

`ifdef RDT_EARLY_PRESS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            early_q <= 1'b0;
        end else begin
            early_q <= early_d;
        end
    end

    assign early = early_q;
`endif

    assign delay_units = delay_units_q;
    assign busy        = (state_q == StWait);
    assign done        = (state_q == StDone);

endmodule

// File: tb/tb_random_delay_timer.sv
// Self-checking bench for random_delay_timer: directed boundary scenarios plus randomized traffic,
// all compared against a cycle-countdown reference model.
module tb_random_delay_timer;

    localparam int VW   = 5;
    localparam int TPU  = 4;
    localparam int MINU = 0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [VW-1:0] random_value = '0;
    logic [VW+7:0] delay_units;
    logic          busy;
    logic          done;
`ifdef RDT_EARLY_PRESS_EN
    logic          press = 1'b0;
    logic          early;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    random_delay_timer #(
        .VALUE_WIDTH   (VW),
        .TICKS_PER_UNIT(TPU),
        .MIN_UNITS     (MINU)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .random_value(random_value),
`ifdef RDT_EARLY_PRESS_EN
        .press       (press),
        .early       (early),
`endif
        .delay_units (delay_units),
        .busy        (busy),
        .done        (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: mode 0=idle, 1=waiting, 2=done; m_left counts remaining wait cycles.
    int m_mode  = 0;
    int m_left  = 0;
    int m_delay = 0;
    bit m_early = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode  <= 0;
            m_left  <= 0;
            m_delay <= 0;
            m_early <= 1'b0;
        end else begin
            m_early <= 1'b0;
            case (m_mode)
                0: begin
                    if (start && !abort) begin
                        m_delay <= int'(random_value) + MINU;
                        m_left  <= ((int'(random_value) + MINU) * TPU > 0) ?
                                   (int'(random_value) + MINU) * TPU : 1;
                        m_mode  <= 1;
                    end
                end
                1: begin
                    if (abort) begin
                        m_mode <= 0;
                    end
`ifdef RDT_EARLY_PRESS_EN
                    else if (press) begin
                        m_mode  <= 0;
                        m_early <= 1'b1;
                    end
`endif
                    else begin
                        m_left <= m_left - 1;
                        if (m_left == 1) m_mode <= 2;
                    end
                end
                default: m_mode <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check_eq("busy", 32'(busy), 32'(m_mode == 1));
            check_eq("done", 32'(done), 32'(m_mode == 2));
            check_eq("delay_units", 32'(delay_units), 32'(m_delay));
`ifdef RDT_EARLY_PRESS_EN
            check_eq("early", 32'(early), 32'(m_early));
`endif
        end
    end

    // Issues a start with rv, then observes limit cycles; optional retrigger/abort at cycle index.
    task automatic scenario(input int rv, input int limit, input int retrig_at, input int abort_at,
                            output int lat, output int busy_cnt, output int done_cnt);
        @(negedge clk);
        start        = 1'b1;
        abort        = 1'b0;
        random_value = VW'(rv);
        lat      = -1;
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            start        = (i == retrig_at);
            abort        = (i == abort_at);
            random_value = (i == retrig_at) ? VW'(9) : VW'($urandom);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (lat < 0) lat = i - 1;
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, bcnt, dcnt;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_delay_units", 32'(delay_units), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        scenario(5, 25, -1, -1, lat, bcnt, dcnt);
        check_eq("nominal_latency", 32'(lat), 32'd20);
        check_eq("nominal_busy_cycles", 32'(bcnt), 32'd20);
        check_eq("nominal_done_pulses", 32'(dcnt), 32'd1);
        check_eq("nominal_delay_units", 32'(delay_units), 32'd5);

        scenario(0, 5, -1, -1, lat, bcnt, dcnt);
        check_eq("zero_latency", 32'(lat), 32'd1);
        check_eq("zero_busy_cycles", 32'(bcnt), 32'd1);
        check_eq("zero_done_pulses", 32'(dcnt), 32'd1);

        scenario(31, 130, -1, -1, lat, bcnt, dcnt);
        check_eq("max_latency", 32'(lat), 32'd124);
        check_eq("max_busy_cycles", 32'(bcnt), 32'd124);
        check_eq("max_delay_units", 32'(delay_units), 32'd31);

        scenario(5, 25, 7, -1, lat, bcnt, dcnt);
        check_eq("retrig_latency", 32'(lat), 32'd20);
        check_eq("retrig_busy_cycles", 32'(bcnt), 32'd20);
        check_eq("retrig_delay_units", 32'(delay_units), 32'd5);

        @(negedge clk);
        start = 1'b1; abort = 1'b1; random_value = VW'(17);
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check_eq("collide_busy", 32'(busy), 32'd0);
        check_eq("collide_delay_units", 32'(delay_units), 32'd5);

        scenario(5, 30, -1, 10, lat, bcnt, dcnt);
        check_eq("abort_mid_busy_cycles", 32'(bcnt), 32'd10);
        check_eq("abort_mid_done_pulses", 32'(dcnt), 32'd0);

        scenario(5, 30, -1, 20, lat, bcnt, dcnt);
        check_eq("abort_last_busy_cycles", 32'(bcnt), 32'd20);
        check_eq("abort_last_done_pulses", 32'(dcnt), 32'd0);

        scenario(6, 30, -1, 25, lat, bcnt, dcnt);
        check_eq("abort_in_done_latency", 32'(lat), 32'd24);
        check_eq("abort_in_done_pulses", 32'(dcnt), 32'd1);

        // Reset asserted between clock edges in the middle of a wait.
        @(negedge clk);
        start = 1'b1; random_value = VW'(5);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_busy", 32'(busy), 32'd0);
        check_eq("async_rst_done", 32'(done), 32'd0);
        check_eq("async_rst_delay_units", 32'(delay_units), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        bcnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) dcnt++;
            if (busy) bcnt++;
        end
        check_eq("post_rst_done_pulses", 32'(dcnt), 32'd0);
        check_eq("post_rst_busy_cycles", 32'(bcnt), 32'd0);

`ifdef RDT_EARLY_PRESS_EN
        begin
            int ecnt;
            @(negedge clk);
            start = 1'b1; random_value = VW'(5);
            ecnt = 0; dcnt = 0; bcnt = 0;
            for (int i = 1; i <= 25; i++) begin
                @(negedge clk);
                start = 1'b0;
                press = (i == 3);
                if (early) ecnt++;
                if (done) dcnt++;
                if (busy) bcnt++;
            end
            press = 1'b0;
            check_eq("press_early_pulses", 32'(ecnt), 32'd1);
            check_eq("press_done_pulses", 32'(dcnt), 32'd0);
            check_eq("press_busy_cycles", 32'(bcnt), 32'd3);

            @(negedge clk);
            press = 1'b1;
            @(negedge clk);
            press = 1'b0;
            check_eq("idle_press_early", 32'(early), 32'd0);
            check_eq("idle_press_busy", 32'(busy), 32'd0);
        end
`endif

        // Randomized traffic; the per-cycle model comparison does the checking.
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            start        = ($urandom_range(0, 7) == 0);
            abort        = ($urandom_range(0, 40) == 0);
            random_value = VW'($urandom);
`ifdef RDT_EARLY_PRESS_EN
            press        = ($urandom_range(0, 60) == 0);
`endif
        end
        start = 1'b0;
        abort = 1'b0;
`ifdef RDT_EARLY_PRESS_EN
        press = 1'b0;
`endif
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/random_delay_timer.md
RANDOM_DELAY_TIMER -- requirements
Module: random_delay_timer

Interface
REQ-001 Parameter VALUE_WIDTH, default 5, SHALL set the width of the random value input (0..31 for the 5-bit default).
REQ-002 Parameter TICKS_PER_UNIT, default 50000, SHALL set the clock cycles per delay unit (1 ms at 50 MHz); legal range is 1 or more.
REQ-003 Parameter MIN_UNITS, default 0, SHALL set a fixed offset added to every sampled value.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 start  input  1  SHALL be a start request, honoured only in IDLE.
REQ-007 abort  input  1  SHALL cancel any delay in progress.
REQ-008 random_value  input  VALUE_WIDTH  SHALL be the value from the rng block, sampled on an accepted start.
REQ-009 delay_units  output  VALUE_WIDTH+8  SHALL hold the latched delay in units: random_value + MIN_UNITS, zero-extended with no overflow.
REQ-010 busy  output  1  SHALL be high while in WAIT.
REQ-011 done  output  1  SHALL be a one-cycle pulse when a delay expires normally.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, WAIT and DONE.
REQ-013 IDLE with start=1 and abort=0 at edge k: the block SHALL latch delay_units, clear the prescaler, load the unit counter and enter WAIT.
REQ-014 In WAIT, the prescaler SHALL count 0..TICKS_PER_UNIT-1; on wrap it SHALL return to 0 and decrement the unit counter.
REQ-015 WAIT SHALL last exactly max(1, delay_units*TICKS_PER_UNIT) cycles, then enter DONE, so done rises at edge k+max(1, delay_units*TICKS_PER_UNIT).
REQ-016 DONE SHALL last one cycle with done=1 and busy=0, then return to IDLE unconditionally.
REQ-017 start SHALL be ignored in WAIT and DONE; it SHALL NOT retrigger, and delay_units SHALL remain unchanged.
REQ-018 abort=1 in WAIT SHALL return the FSM to IDLE at the next edge with no done pulse; abort has priority over expiry in the same cycle.
REQ-019 abort=1 in DONE SHALL NOT suppress the done pulse already being driven.
REQ-020 start and abort both high in IDLE SHALL leave the FSM in IDLE with delay_units unchanged.
REQ-021 delay_units SHALL hold its value until the next accepted start, including across abort.
REQ-022 Counter widths SHALL accommodate (2^VALUE_WIDTH-1+MIN_UNITS)*TICKS_PER_UNIT without wrap.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, delay_units=0, and clear the prescaler and unit counter, regardless of clock.
REQ-024 Reset asserted mid-WAIT SHALL discard the delay; after release, the block SHALL wait for a new start.

Configuration
REQ-025 Macro RDT_EARLY_PRESS_EN defined: the block SHALL add input press (1 bit) and output early (1 bit).
REQ-026 With RDT_EARLY_PRESS_EN, press=1 in WAIT SHALL return the FSM to IDLE at the next edge, pulse early for one cycle and suppress done.
REQ-027 With RDT_EARLY_PRESS_EN, abort SHALL take priority over press, and press SHALL be ignored outside WAIT; early SHALL reset to 0.
REQ-028 Macro undefined: the press and early ports SHALL NOT exist, and behaviour SHALL be exactly REQ-012..REQ-024.

Verification
Bench parameters for all scenarios: TICKS_PER_UNIT=4, MIN_UNITS=0, VALUE_WIDTH=5.
REQ-029 Nominal delay: random_value=5, start pulse at edge k -> delay_units=5, busy high for 20 cycles, done high for one cycle starting at edge k+20.
REQ-030 Zero and maximum values: random_value=0 -> done at edge k+1; random_value=31 -> done at edge k+124, busy=1 throughout.
REQ-031 Retrigger and collision: start re-pulsed mid-WAIT with random_value=9 -> timing and delay_units=5 unchanged; start and abort together in IDLE -> FSM stays IDLE.
REQ-032 Abort: abort at cycle 10 of a 20-cycle WAIT -> IDLE next edge, no done; abort coincident with the final WAIT cycle -> no done.
REQ-033 Reset: rst_n low mid-WAIT between clock edges -> busy, done and delay_units go to 0 immediately; no done after release.
REQ-034 RDT_EARLY_PRESS_EN: press at cycle 3 of WAIT -> early pulses one cycle, no done; press in IDLE -> no effect.
